// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command codes, bus widths, don't-care values and
// 100 MHz timing constants, plus the auto-refresh FSM state type.
package sdram_pkg;

    localparam int unsigned BANK_W = 2;
    localparam int unsigned ADDR_W = 13;

    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_AR  = 4'b0001;
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_MRS = 4'b0000;

    localparam logic [BANK_W-1:0] BANK_DC = 2'b11;
    localparam logic [ADDR_W-1:0] ADDR_DC = 13'h1fff;

    localparam int unsigned TRP         = 2;
    localparam int unsigned TRFC        = 7;
    localparam int unsigned CNT_REF_MAX = 750;
    localparam int unsigned AR_NUM      = 2;

    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StTrp,
        StAr,
        StTrfc,
        StEnd
    } aref_state_e;

    function automatic logic [3:0] aref_cmd_of(aref_state_e s);
        logic [3:0] cmd;
        cmd = CMD_NOP;
        unique case (s)
            StPre:   cmd = CMD_PRE;
            StAr:    cmd = CMD_AR;
            default: cmd = CMD_NOP;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/sdram_aref_if.sv
// Arbiter-facing bundle of the auto-refresh controller; the controller uses
// the slave modport, the arbiter/init side the master modport.
interface sdram_aref_if;
    import sdram_pkg::*;

    logic                init_end;
    logic                aref_en;
    logic                aref_req;
    logic                aref_end;
    logic                aref_ovf;
    logic [3:0]          aref_cmd;
    logic [BANK_W-1:0]   aref_bank;
    logic [ADDR_W-1:0]   aref_addr;

    modport master (
        output init_end, aref_en,
        input  aref_req, aref_end, aref_ovf, aref_cmd, aref_bank, aref_addr
    );

    modport slave (
        input  init_end, aref_en,
        output aref_req, aref_end, aref_ovf, aref_cmd, aref_bank, aref_addr
    );

endinterface

// File: rtl/sdram_aref_timer.sv
// Refresh-interval counter with request set/clear. Missed-interval detection
// is built only when SDRAM_AREF_OVF_EN is defined.
module sdram_aref_timer #(
    parameter int unsigned CNT_REF_MAX = 750
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic init_end_i,
    input  logic aref_en_i,
    input  logic fsm_idle_i,
    output logic aref_req_o,
    output logic grant_o,
    output logic aref_ovf_o
);

    localparam int unsigned CntW = (CNT_REF_MAX > 1) ? $clog2(CNT_REF_MAX) : 1;

    logic [CntW-1:0] cnt_ref_q, cnt_ref_d;
    logic            aref_req_q, aref_req_d;
    logic            wrap;
    logic            grant;

    assign wrap  = init_end_i && (cnt_ref_q == CntW'(CNT_REF_MAX - 1));
    assign grant = aref_en_i && fsm_idle_i && aref_req_q;

    always_comb begin
        cnt_ref_d = '0;
        if (init_end_i && !wrap) begin
            cnt_ref_d = cnt_ref_q + CntW'(1);
        end
    end

    // Losing init clears the request; otherwise a wrap outranks a grant.
    always_comb begin
        aref_req_d = aref_req_q;
        if (!init_end_i) begin
            aref_req_d = 1'b0;
        end else if (wrap) begin
            aref_req_d = 1'b1;
        end else if (grant) begin
            aref_req_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_ref_q  <= '0;
            aref_req_q <= 1'b0;
        end else begin
            cnt_ref_q  <= cnt_ref_d;
            aref_req_q <= aref_req_d;
        end
    end

`ifdef SDRAM_AREF_OVF_EN
    logic aref_ovf_q, aref_ovf_d;

    assign aref_ovf_d = aref_ovf_q | (wrap && aref_req_q && !grant);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            aref_ovf_q <= 1'b0;
        end else begin
            aref_ovf_q <= aref_ovf_d;
        end
    end

    assign aref_ovf_o = aref_ovf_q;
`else
    assign aref_ovf_o = 1'b0;
`endif

    assign aref_req_o = aref_req_q;
    assign grant_o    = grant;

endmodule

// File: rtl/sdram_aref.sv
// SDRAM auto-refresh controller: PRECHARGE-all then AR_NUM AUTO REFRESH per
// granted burst. Optional sticky overflow flag via SDRAM_AREF_OVF_EN.
module sdram_aref #(
    parameter int unsigned CNT_REF_MAX = sdram_pkg::CNT_REF_MAX,
    parameter int unsigned TRP         = sdram_pkg::TRP,
    parameter int unsigned TRFC        = sdram_pkg::TRFC,
    parameter int unsigned AR_NUM      = sdram_pkg::AR_NUM
) (
    input  logic         aref_clk,
    input  logic         aref_rst,
    sdram_aref_if.slave  bus
);
    import sdram_pkg::*;

    aref_state_e state_q, state_d;
    logic [3:0]  clk_cnt_q, clk_cnt_d;
    logic [3:0]  ar_cnt_q, ar_cnt_d;
    logic [3:0]  cmd_q, cmd_d;
    logic        end_q, end_d;
    logic        grant;

    sdram_aref_timer #(
        .CNT_REF_MAX (CNT_REF_MAX)
    ) u_timer (
        .clk_i      (aref_clk),
        .rst_i      (aref_rst),
        .init_end_i (bus.init_end),
        .aref_en_i  (bus.aref_en),
        .fsm_idle_i (state_q == StIdle),
        .aref_req_o (bus.aref_req),
        .grant_o    (grant),
        .aref_ovf_o (bus.aref_ovf)
    );

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q + 4'd1;
        ar_cnt_d  = ar_cnt_q;
        unique case (state_q)
            StIdle: begin
                clk_cnt_d = '0;
                ar_cnt_d  = '0;
                if (grant) begin
                    state_d = StPre;
                end
            end
            StPre: begin
                clk_cnt_d = '0;
                state_d   = StTrp;
            end
            StTrp: begin
                if (clk_cnt_q == 4'(TRP - 1)) begin
                    clk_cnt_d = '0;
                    state_d   = StAr;
                end
            end
            StAr: begin
                clk_cnt_d = '0;
                ar_cnt_d  = ar_cnt_q + 4'd1;
                state_d   = StTrfc;
            end
            StTrfc: begin
                if (clk_cnt_q == 4'(TRFC - 1)) begin
                    clk_cnt_d = '0;
                    state_d   = (ar_cnt_q < 4'(AR_NUM)) ? StAr : StEnd;
                end
            end
            StEnd: begin
                clk_cnt_d = '0;
                state_d   = StIdle;
            end
            default: begin
                clk_cnt_d = '0;
                state_d   = StIdle;
            end
        endcase
    end

    // Command and done pulse are registered from the current state.
    always_comb begin
        cmd_d = aref_cmd_of(state_q);
        end_d = (state_q == StEnd);
    end

    always_ff @(posedge aref_clk) begin
        if (aref_rst) begin
            state_q   <= StIdle;
            clk_cnt_q <= '0;
            ar_cnt_q  <= '0;
            cmd_q     <= CMD_NOP;
            end_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            ar_cnt_q  <= ar_cnt_d;
            cmd_q     <= cmd_d;
            end_q     <= end_d;
        end
    end

    assign bus.aref_cmd  = cmd_q;
    assign bus.aref_end  = end_q;
    assign bus.aref_bank = BANK_DC;
    assign bus.aref_addr = ADDR_DC;

endmodule

// File: tb/tb_sdram_aref.sv
// Self-checking bench for sdram_aref against a timeline-based reference model.
module tb_sdram_aref;
    import sdram_pkg::*;

    localparam int MAX   = 750;
    localparam int TRPV  = 2;
    localparam int TRFCV = 7;
    localparam int ARN   = 2;
    localparam int L     = 2 + TRPV + ARN * (1 + TRFCV);
    localparam logic [21:0] RST_V = {3'b000, 4'b0111, 2'b11, 13'h1fff};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sdram_aref_if bus ();

    sdram_aref #(
        .CNT_REF_MAX (MAX),
        .TRP         (TRPV),
        .TRFC        (TRFCV),
        .AR_NUM      (ARN)
    ) dut (
        .aref_clk (clk),
        .aref_rst (rst),
        .bus      (bus)
    );

    int total = 0;
    int bad   = 0;

    // Model: burst timeline is anchored at the grant cycle m_g; the interval
    // phase is the distance from the first cycle init_end was seen high.
    int cyc  = 0;
    int m_g  = -100000;
    int m_t0 = 0;
    bit m_run = 1'b0;
    bit m_req = 1'b0;
    bit m_ovf = 1'b0;
    logic m_idle, m_wrap, m_grant;
    logic [21:0] exp_v, obs_v;

    always_comb begin
        m_idle  = !(cyc >= m_g + 1 && cyc <= m_g + L);
        m_wrap  = bus.init_end && m_run && (((cyc - m_t0) % MAX) == MAX - 1);
        m_grant = bus.aref_en && m_idle && m_req;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_g   <= -100000;
            m_run <= 1'b0;
            m_req <= 1'b0;
            m_ovf <= 1'b0;
        end else begin
            if (!bus.init_end) m_run <= 1'b0;
            else if (!m_run) begin
                m_run <= 1'b1;
                m_t0  <= cyc;
            end
            if (!bus.init_end) m_req <= 1'b0;
            else if (m_wrap)   m_req <= 1'b1;
            else if (m_grant)  m_req <= 1'b0;
            if (m_grant) m_g <= cyc;
`ifdef SDRAM_AREF_OVF_EN
            if (m_wrap && m_req && !m_grant) m_ovf <= 1'b1;
`endif
        end
    end

    always_comb begin
        int d;
        logic [3:0] c;
        d = cyc - m_g;
        c = 4'b0111;
        if (d == 2) c = 4'b0010;
        for (int k = 0; k < ARN; k++) begin
            if (d == 3 + TRPV + k * (1 + TRFCV)) c = 4'b0001;
        end
        exp_v = {m_req, (d == L + 1), m_ovf, c, 2'b11, 13'h1fff};
        obs_v = {bus.aref_req, bus.aref_end, bus.aref_ovf, bus.aref_cmd, bus.aref_bank,
                 bus.aref_addr};
    end

    task automatic test_reset();
        rst = 1'b1;
        bus.init_end = 1'b0;
        bus.aref_en  = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (obs_v !== RST_V) begin
            bad++;
            $display("FAIL reset got=%h want=%h", obs_v, RST_V);
        end
        rst = 1'b0;
    endtask

    task automatic test_idle_req();
        int tr = -1;
        for (int i = 0; i < 780; i++) begin
            @(negedge clk);
            total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("FAIL idle_req cyc=%0d got=%h want=%h", cyc, obs_v, exp_v);
            end
            if (bus.aref_req && tr < 0) tr = i;
            if (i == 10) bus.init_end = 1'b1;
        end
        total++;
        if (tr !== 10 + MAX) begin
            bad++;
            $display("FAIL first_req_time got=%0d want=%0d", tr, 10 + MAX);
        end
    endtask

    task automatic test_grant();
        int dly = $urandom_range(0, 20);
        int ends = 0;
        for (int i = 0; i < dly + 30; i++) begin
            @(negedge clk);
            total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("FAIL grant cyc=%0d got=%h want=%h", cyc, obs_v, exp_v);
            end
            if (bus.aref_end) ends++;
            bus.aref_en = (i == dly);
        end
        total++;
        if (ends !== 1) begin
            bad++;
            $display("FAIL grant_end_count got=%0d want=1", ends);
        end
    endtask

    task automatic test_spurious();
        int ends = 0;
        int gi = -1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("FAIL spurious cyc=%0d got=%h want=%h", cyc, obs_v, exp_v);
            end
            if (bus.aref_end) ends++;
            if (gi < 0) begin
                // Random pulses while no request is pending, then a real grant.
                bus.aref_en = m_req ? 1'b1 : ($urandom_range(0, 3) == 0);
                if (m_req) gi = i;
            end else begin
                bus.aref_en = (i > gi + 2 && i < gi + 19) ? ($urandom_range(0, 1) == 1) : 1'b0;
                if (i > gi + 30) break;
            end
        end
        total++;
        if (gi < 0 || ends !== 1) begin
            bad++;
            $display("FAIL spurious_end_count got=%0d want=1 granted=%0d", ends, gi >= 0);
        end
    endtask

    task automatic test_wrap_grant();
        int seen = 0;
        int gi = -1;
        bus.aref_en = 1'b0;
        for (int i = 0; i < 1700; i++) begin
            @(negedge clk);
            total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("FAIL wrap_grant cyc=%0d got=%h want=%h", cyc, obs_v, exp_v);
            end
            bus.aref_en = 1'b0;
            if (gi < 0 && m_req) begin
                if (m_wrap) begin
                    seen++;
                    if (seen == 1 && i > 0) begin
                        bus.aref_en = 1'b1;
                        gi = i;
                    end
                end
            end
            if (gi >= 0 && i > gi + 30) break;
        end
        total++;
        if (gi < 0 || bus.aref_req !== 1'b1 || bus.aref_ovf !== 1'b0) begin
            bad++;
            $display("FAIL wrap_grant_after req=%b ovf=%b want req=1 ovf=0 granted=%0d",
                     bus.aref_req, bus.aref_ovf, gi >= 0);
        end
    endtask

    task automatic test_ovf();
        logic want;
`ifdef SDRAM_AREF_OVF_EN
        want = 1'b1;
`else
        want = 1'b0;
`endif
        for (int i = 0; i < 2 * MAX + 40; i++) begin
            @(negedge clk);
            total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("FAIL ovf cyc=%0d got=%h want=%h", cyc, obs_v, exp_v);
            end
            bus.aref_en = (i == 2 * MAX + 5);
        end
        total++;
        if (bus.aref_ovf !== want) begin
            bad++;
            $display("FAIL ovf_sticky got=%b want=%b", bus.aref_ovf, want);
        end
    endtask

    task automatic test_init_drop();
        int gi = -1;
        int off = $urandom_range(2, 15);
        for (int i = 0; i < 900; i++) begin
            @(negedge clk);
            total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("FAIL init_drop cyc=%0d got=%h want=%h", cyc, obs_v, exp_v);
            end
            bus.aref_en = (gi < 0 && m_req);
            if (gi < 0 && m_req) gi = i;
            if (gi >= 0 && i == gi + off) bus.init_end = 1'b0;
            if (gi >= 0 && i > gi + 28) break;
        end
        total++;
        if (gi < 0 || bus.aref_req !== 1'b0) begin
            bad++;
            $display("FAIL init_drop_req got=%b want=0 granted=%0d", bus.aref_req, gi >= 0);
        end
        bus.init_end = 1'b1;
    endtask

    task automatic test_reset_mid();
        int gi = -1;
        for (int i = 0; i < 900; i++) begin
            @(negedge clk);
            total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("FAIL reset_mid cyc=%0d got=%h want=%h", cyc, obs_v, exp_v);
            end
            if (gi >= 0 && i == gi + 7) begin
                total++;
                if (obs_v !== RST_V) begin
                    bad++;
                    $display("FAIL reset_mid_vals got=%h want=%h", obs_v, RST_V);
                end
            end
            bus.aref_en = (gi < 0 && m_req);
            if (gi < 0 && m_req) gi = i;
            rst = (gi >= 0 && i == gi + 6);
            if (gi >= 0 && i > gi + 40) break;
        end
        total++;
        if (gi < 0) begin
            bad++;
            $display("FAIL reset_mid_timeout got=no_request want=request");
        end
    endtask

    initial begin
        test_reset();
        test_idle_req();
        test_grant();
        test_spurious();
        test_wrap_grant();
        test_ovf();
        test_init_drop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
